// File: rtl/adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder/subtractor.
package adder_pkg;

  // Subtraction is a + ~b + 1, so the carry into the LSB chunk is forced high.
  localparam logic SUB_CIN = 1'b1;

  function automatic int calc_cw(input int width, input int stages);
    return (stages > 0) ? (width / stages) : 0;
  endfunction

  function automatic bit params_legal(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One registered CW-bit slice of the carry chain; low result bits and the
// still-unprocessed operand bits travel along with the slice carry.
module adder_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = 30,
  parameter int CW    = 10,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_carry,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_carry,
  output logic [WIDTH-1:0] out_sum,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b
);

  localparam int LO = IDX * CW;

  logic [CW:0]      chunk;
  logic [WIDTH-1:0] next_sum;
  logic             valid_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  assign chunk = {1'b0, in_a[LO +: CW]} + {1'b0, in_b[LO +: CW]} + {{CW{1'b0}}, in_carry};

  // NOTE: every variable assigned in always_comb gets a full default first,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    next_sum           = in_sum;
    next_sum[LO +: CW] = chunk[CW-1:0];
  end

  // A slot can take new data when it is empty or its occupant leaves this cycle.
  assign in_ready = !valid_q || out_ready;

  // NOTE: data registers are reset too, not just the valid bit, because the
  // result and flags are visible on the outputs and must read zero in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else if (in_ready) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      valid_q <= in_valid;
      if (in_valid) begin
        carry_q <= chunk[CW];
        sum_q   <= next_sum;
        a_q     <= in_a;
        b_q     <= in_b;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_carry = carry_q;
  assign out_sum   = sum_q;
  assign out_a     = a_q;
  assign out_b     = b_q;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor: STAGES chunk adders in a
// valid/ready chain, with b inversion up front and flags from the last stage.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 30,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = calc_cw(WIDTH, STAGES);

  if (!params_legal(WIDTH, STAGES)) begin : g_param_check
    $error("pipelined_adder: WIDTH must be >= 1, STAGES >= 1 and WIDTH divisible by STAGES");
  end

  // Index k is the input side of stage k; index STAGES is the output side.
  logic             valid_w [STAGES+1];
  logic             ready_w [STAGES+1];
  logic             carry_w [STAGES+1];
  logic [WIDTH-1:0] sum_w   [STAGES+1];
  logic [WIDTH-1:0] a_w     [STAGES+1];
  logic [WIDTH-1:0] b_w     [STAGES+1];

  assign valid_w[0]      = in_valid;
  assign carry_w[0]      = sub ? SUB_CIN : cin;
  assign sum_w[0]        = '0;
  assign a_w[0]          = a;
  assign b_w[0]          = sub ? ~b : b;
  assign ready_w[STAGES] = out_ready;
  assign in_ready        = ready_w[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_stage #(
      .WIDTH (WIDTH),
      .CW    (CW),
      .IDX   (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (valid_w[k]),
      .in_ready  (ready_w[k]),
      .in_carry  (carry_w[k]),
      .in_sum    (sum_w[k]),
      .in_a      (a_w[k]),
      .in_b      (b_w[k]),
      .out_valid (valid_w[k+1]),
      .out_ready (ready_w[k+1]),
      .out_carry (carry_w[k+1]),
      .out_sum   (sum_w[k+1]),
      .out_a     (a_w[k+1]),
      .out_b     (b_w[k+1])
    );
  end

  assign out_valid = valid_w[STAGES];
  assign sum       = sum_w[STAGES];
  assign cout      = carry_w[STAGES];
  // Operands of equal sign producing a result of the other sign.
  assign ovf = (a_w[STAGES][WIDTH-1] == b_w[STAGES][WIDTH-1]) &&
               (sum_w[STAGES][WIDTH-1] != a_w[STAGES][WIDTH-1]);

  // Only the operand MSBs are needed past the last stage.
  logic unused_ops;
  assign unused_ops = ^{a_w[STAGES], b_w[STAGES]};

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined two's-complement adder/subtractor with a valid/ready handshake on both sides.
- Generalises the fixed 30-bit combinational full adder used in instruction fetch:
  - configurable width and pipeline depth
  - add/subtract mode
  - carry-out and signed-overflow flags
  - back-pressure support
- Intended for PC/branch-target arithmetic and ALU datapaths where the full-width carry chain must be split across cycles.

Parameters:
- WIDTH, 30, operand and result width in bits; must be ≥ 1.
- STAGES, 3, number of register stages; must be ≥ 1, and WIDTH must be divisible by STAGES (elaboration error otherwise).
- CW, WIDTH/STAGES, derived chunk width; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry in (ignored when sub=1)
- sub  input  1  1: compute a + ~b + 1; 0: compute a + b + cin
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  carry out of MSB
- ovf  output  1  signed overflow: operand MSBs (after inversion of b for sub) equal and differ from sum MSB

Behaviour:
- Reset: clk and rst_n are the single clock and reset. Reset is asynchronous, active-low.
  - While rst_n=0, all stage valid bits clear.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready reflects the empty pipe (1) once rst_n deasserts.
- Transfers: an input transfer occurs when in_valid & in_ready; an output transfer when out_valid & out_ready.
- Stage chain: stages 0..STAGES-1, each holding one valid bit.
  - Stage k adds chunk k (bits k*CW .. k*CW+CW-1) of a and effective-b, plus the carry registered by stage k-1.
  - Stage 0 uses cin, or 1 when sub=1.
  - Each stage forwards the already-computed low sum bits and the not-yet-processed high operand bits.
- Ready chain: ready[k] = !valid[k] | ready[k+1], with ready[STAGES] = out_ready.
  - in_ready = ready[0]. This is combinational from out_ready; documented and permitted.
- Throughput and latency:
  - One result per cycle when out_ready stays high.
  - Latency from input transfer to out_valid is exactly STAGES cycles.
- Outputs: out_valid, sum, cout and ovf are driven from the last stage register. They hold stable while out_valid=1 & out_ready=0.
- Stalls: a stalled stage keeps its data. Upstream stages fill bubbles but never overwrite a valid stage that is not advancing.
- Ordering: results leave in input order; no reordering and no drops.
- Simultaneous fill/drain: when the pipe is full and out_ready=1, a new input is accepted in the same cycle as the output transfer.
- Reset mid-operation: all in-flight operations are discarded. After rst_n rises, no stale results appear.
- Wrap-around: the sum wraps modulo 2^WIDTH. cout carries the lost bit.
  - For sub, cout=1 means no borrow (a ≥ b unsigned).
- STAGES=1: a single registered adder with latency 1.

Decomposition:
- Shared package/header adder_pkg:
  - constant function for CW
  - parameter legality check
  - localparams for the sub-mode carry-in value
- One sub-module, adder_stage: a registered CW-bit chunk adder. It has the valid bit, a local ready, carry in/out, and pass-through of partial sum and pending operand bits.
- pipelined_adder: a generate loop of STAGES adder_stage instances, plus b-inversion and flag computation.

Test Plan:
All scenarios use WIDTH=30, STAGES=3.
- Basic add: a=1, b=1, cin=1, sub=0 → after 3 cycles, sum=3, cout=0, ovf=0.
- Carry out: a=0x3FFFFFFF, b=0, cin=1 → sum=0, cout=1, ovf=0. Then a=b=0x3FFFFFFF, cin=1 → sum=0x3FFFFFFF, cout=1, ovf=0. Then a=1000, b=1500, cin=1 → sum=2501.
- Subtract and overflow:
  - sub=1, a=5, b=7 → sum=0x3FFFFFFE, cout=0, ovf=0.
  - sub=0, a=0x1FFFFFFF, b=0, cin=1 → sum=0x20000000, ovf=1.
- Back-pressure: stream 6 back-to-back adds (a=i, b=10*i, cin=0) with out_ready low in cycles 4-7.
  - in_ready must drop once 3 results are buffered.
  - Outputs must hold stable while stalled.
  - All 6 sums (11*i) must appear in order with no duplicates.
- Full throughput: 20 random operand pairs with out_ready=1 → exactly one result per cycle after 3-cycle latency; every result matches the reference model, including cout and ovf.
- Reset mid-stream: assert rst_n=0 asynchronously between edges with 2 operations in flight.
  - out_valid must drop to 0 immediately.
  - After release, no result appears until a new input is accepted 3 cycles earlier.
